// File: rtl/pll_seq_pkg.sv
// Shared state encoding and widths for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } seq_state_t;

  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

endpackage

// File: rtl/sync2_bit.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module sync2_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, then releases the core reset; re-sequences on lock loss.
// Define PLL_SEQ_RETRY_EN to add lock timeout, bounded retries and a FAULT state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  restart_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

  seq_state_t            state_reg, state_next;
  logic [RST_W-1:0]      rst_cnt_reg, rst_cnt_next;
  logic [STB_W-1:0]      stb_cnt_reg, stb_cnt_next;
  logic [LOST_CNT_W-1:0] lost_cnt_reg, lost_cnt_next;
  logic                  pll_rst_reg, sys_rst_n_reg, ready_reg;
  logic                  locked_s;

`ifdef PLL_SEQ_RETRY_EN
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
  logic [RETRY_W-1:0] retry_inc;
  logic               fault_reg;
`else
  // Retry parameters have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = (LOCK_TIMEOUT > 0) ^ (MAX_RETRIES > 0);
`endif

  sync2_bit u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_next    = state_reg;
    rst_cnt_next  = rst_cnt_reg;
    stb_cnt_next  = stb_cnt_reg;
    lost_cnt_next = lost_cnt_reg;
`ifdef PLL_SEQ_RETRY_EN
    tmo_cnt_next   = tmo_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    retry_inc      = retry_cnt_reg + RETRY_W'(1);
`endif
    // A restart overrides every transition, including a lock loss seen in RUN.
    if (restart_req) begin
      state_next   = RESET_PLL;
      rst_cnt_next = '0;
      stb_cnt_next = '0;
`ifdef PLL_SEQ_RETRY_EN
      tmo_cnt_next   = '0;
      retry_cnt_next = '0;
`endif
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next   = WAIT_LOCK;
            rst_cnt_next = '0;
`ifdef PLL_SEQ_RETRY_EN
            tmo_cnt_next = '0;
`endif
          end else begin
            rst_cnt_next = rst_cnt_reg + RST_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next   = STABLE;
            stb_cnt_next = '0;
          end
`ifdef PLL_SEQ_RETRY_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            tmo_cnt_next   = '0;
            retry_cnt_next = retry_inc;
            state_next     = (retry_inc == RETRY_MAX) ? FAULT : RESET_PLL;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          end
`endif
        end
        STABLE: begin
          // A dropout only restarts qualification; the PLL is not reset again.
          if (!locked_s) begin
            state_next = WAIT_LOCK;
`ifdef PLL_SEQ_RETRY_EN
            tmo_cnt_next = '0;
`endif
          end else if (stb_cnt_reg == STB_LAST) begin
            state_next = RUN;
`ifdef PLL_SEQ_RETRY_EN
            retry_cnt_next = '0;
`endif
          end else begin
            stb_cnt_next = stb_cnt_reg + STB_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_next   = RESET_PLL;
            rst_cnt_next = '0;
            if (lost_cnt_reg != LOST_CNT_MAX) begin
              lost_cnt_next = lost_cnt_reg + LOST_CNT_W'(1);
            end
          end
        end
`ifdef PLL_SEQ_RETRY_EN
        FAULT: begin
          state_next = FAULT;
        end
`endif
        default: begin
          state_next   = RESET_PLL;
          rst_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET_PLL;
      rst_cnt_reg   <= '0;
      stb_cnt_reg   <= '0;
      lost_cnt_reg  <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rst_cnt_reg   <= rst_cnt_next;
      stb_cnt_reg   <= stb_cnt_next;
      lost_cnt_reg  <= lost_cnt_next;
      pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAULT);
      sys_rst_n_reg <= (state_next == RUN);
      ready_reg     <= (state_next == RUN);
    end
  end

`ifdef PLL_SEQ_RETRY_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg   <= '0;
      retry_cnt_reg <= '0;
      fault_reg     <= 1'b0;
    end else begin
      tmo_cnt_reg   <= tmo_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      fault_reg     <= (state_next == FAULT);
    end
  end

  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign pll_rst   = pll_rst_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign ready     = ready_reg;
  assign lost_cnt  = lost_cnt_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (RST=4, STABLE=8, TIMEOUT=32, RETRIES=2).
// Retry/fault vectors are selected by PLL_SEQ_RETRY_EN, matching the RTL build.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lost_cnt;

  int n_vec;
  int n_err;
  int exp_lost;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .restart_req (restart_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .lost_cnt    (lost_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_release(input string tag, input int budget);
    int n;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, sys_rst_n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_lost_cnt", lost_cnt, 0);

    // T1 power-up: lock at cycle 10, release at cycle 21
    @(posedge refclk);
    #1 rst_n = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (c == 10) pll_locked = 1'b1;
      check("t1_pll_rst", pll_rst, (c < 4));
      check("t1_sys_rst_n", sys_rst_n, (c >= 21));
      check("t1_ready", ready, (c >= 21));
      if (c < 21) tick();
    end

    // T3 lock loss in RUN: core reset 3 cycles later, 4-cycle PLL pulse
    for (int k = 0; k <= 7; k++) begin
      if (k == 0) pll_locked = 1'b0;
      check("t3_sys_rst_n", sys_rst_n, (k < 3));
      check("t3_lost_cnt", lost_cnt, (k >= 3));
      check("t3_pll_rst", pll_rst, (k >= 3 && k <= 6));
      if (k < 7) tick();
    end

    // T2 glitch while qualifying: no PLL reset, release 17 cycles after first lock
    for (int j = 0; j <= 17; j++) begin
      pll_locked = (j != 5);
      check("t2_pll_rst", pll_rst, 0);
      check("t2_sys_rst_n", sys_rst_n, (j >= 17));
      if (j < 17) tick();
    end

    // T6 restart coincident with synchronized lock loss: lost_cnt unchanged
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) pll_locked = 1'b0;
      restart_req = (k == 2);
      if (k == 2) check("t6_sys_rst_n_pre", sys_rst_n, 1);
      if (k >= 3) begin
        check("t6_lost_cnt", lost_cnt, 1);
        check("t6_pll_rst", pll_rst, 1);
        check("t6_sys_rst_n", sys_rst_n, 0);
      end
      if (k < 4) tick();
    end

    // T4 saturation: 256 further lock losses
    exp_lost = 1;
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      wait_release("t4_release", 40);
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
      check("t4_lost_cnt", lost_cnt, exp_lost);
    end

    // T6 async reset while in STABLE
    pll_locked = 1'b1;
    repeat (7) tick();
    check("t6s_pll_rst_pre", pll_rst, 0);
    check("t6s_sys_rst_n_pre", sys_rst_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6s_pll_rst", pll_rst, 1);
    check("t6s_sys_rst_n", sys_rst_n, 0);
    check("t6s_ready", ready, 0);
    check("t6s_fault", fault, 0);
    check("t6s_lost_cnt", lost_cnt, 0);

    // T5 lock never arrives
    pll_locked = 1'b0;
    @(posedge refclk);
    #1 rst_n = 1'b1;
`ifdef PLL_SEQ_RETRY_EN
    for (int c = 0; c <= 79; c++) begin
      check("t5_pll_rst", pll_rst, (c < 4 || (c >= 36 && c <= 39) || c >= 72));
      check("t5_fault", fault, (c >= 72));
      if (c < 79) tick();
    end
    tick();
    restart_req = 1'b1;
    check("t5_fault_held", fault, 1);
    tick();
    restart_req = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      check("t5r_pll_rst", pll_rst, (k < 4 || k >= 36));
      check("t5r_fault", fault, 0);
      if (k < 36) tick();
    end
`else
    for (int c = 0; c <= 79; c++) begin
      check("t5_pll_rst", pll_rst, (c < 4));
      check("t5_fault", fault, 0);
      check("t5_sys_rst_n", sys_rst_n, 0);
      if (c < 79) tick();
    end
`endif
    pll_locked = 1'b1;
    wait_release("t5_release", 60);
    check("t5_ready", ready, 1);
    check("t5_fault_end", fault, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
